// File: rtl/operand_collector_if.sv
// Issue/RF-return/dispatch bundle between the operand collector and its neighbours.
// master = issue/RF/execute side, slave = collector.
interface operand_collector_if;
  logic         Alloc_Valid;
  logic         Alloc_Ready;
  logic [31:0]  Alloc_Instr;
  logic         Alloc_Src1_Need;
  logic         Alloc_Src2_Need;
  logic [2:0]   Alloc_OCID;
  logic         RF_Data_Valid;
  logic [3:0]   RF_OCID;
  logic [255:0] RF_Data;
  logic         Disp_Valid;
  logic         Disp_Ready;
  logic [31:0]  Disp_Instr;
  logic [255:0] Disp_Src1;
  logic [255:0] Disp_Src2;
  logic [2:0]   Disp_OCID;
  logic         Err_Illegal_Write;

  modport master (
    output Alloc_Valid, Alloc_Instr, Alloc_Src1_Need, Alloc_Src2_Need,
    output RF_Data_Valid, RF_OCID, RF_Data, Disp_Ready,
    input  Alloc_Ready, Alloc_OCID, Disp_Valid, Disp_Instr, Disp_Src1, Disp_Src2,
    input  Disp_OCID, Err_Illegal_Write
  );

  modport slave (
    input  Alloc_Valid, Alloc_Instr, Alloc_Src1_Need, Alloc_Src2_Need,
    input  RF_Data_Valid, RF_OCID, RF_Data, Disp_Ready,
    output Alloc_Ready, Alloc_OCID, Disp_Valid, Disp_Instr, Disp_Src1, Disp_Src2,
    output Disp_OCID, Err_Illegal_Write
  );
endinterface

// File: rtl/operand_collector.sv
// NUM_CU collector units gather two RF operand rows per instruction; dispatch is round-robin, valid 1 cycle after last operand, held stable under Disp_Ready=0.
// OC_ERR_CHECK_EN builds the sticky illegal-RF-write flag; otherwise Err_Illegal_Write is tied 0.
module operand_collector #(
  parameter int NUM_CU = 8
) (
  input  logic               clk,
  input  logic               rst,
  operand_collector_if.slave oc
);
  typedef enum logic [1:0] {
    CU_FREE    = 2'd0,
    CU_COLLECT = 2'd1,
    CU_READY   = 2'd2
  } cu_state_e;

  localparam logic [3:0] NUM_CU_W = 4'(NUM_CU);

  cu_state_e    state_q [NUM_CU];
  cu_state_e    state_d [NUM_CU];
  logic [31:0]  instr_q [NUM_CU];
  logic [31:0]  instr_d [NUM_CU];
  logic [255:0] src1_q  [NUM_CU];
  logic [255:0] src1_d  [NUM_CU];
  logic [255:0] src2_q  [NUM_CU];
  logic [255:0] src2_d  [NUM_CU];
  logic         need1_q [NUM_CU];
  logic         need1_d [NUM_CU];
  logic         need2_q [NUM_CU];
  logic         need2_d [NUM_CU];
  logic         got1_q  [NUM_CU];
  logic         got1_d  [NUM_CU];
  logic         got2_q  [NUM_CU];
  logic         got2_d  [NUM_CU];
  logic [2:0]   rr_ptr_q, rr_ptr_d;
  logic         hold_vld_q, hold_vld_d;
  logic [2:0]   hold_idx_q, hold_idx_d;

  logic         any_free;
  logic [2:0]   free_idx;
  logic         any_ready;
  logic [2:0]   sel_idx;
  logic [3:0]   cand;
  logic [2:0]   rf_idx;
  logic         rf_slot;
  logic         rf_accept;
  logic         alloc_fire;
  logic         disp_fire;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int k = NUM_CU - 1; k >= 0; k--) begin
      if (state_q[k] == CU_FREE) begin
        any_free = 1'b1;
        free_idx = 3'(k);
      end
    end
  end

  // A stalled offer is pinned so a CU turning READY behind it cannot steal the slot.
  always_comb begin
    any_ready = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_CU - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= NUM_CU_W) cand = cand - NUM_CU_W;
      if (state_q[cand[2:0]] == CU_READY) begin
        any_ready = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
    if (hold_vld_q) sel_idx = hold_idx_q;
  end

  always_comb begin
    for (int k = 0; k < NUM_CU; k++) begin
      state_d[k] = state_q[k];
      instr_d[k] = instr_q[k];
      src1_d[k]  = src1_q[k];
      src2_d[k]  = src2_q[k];
      need1_d[k] = need1_q[k];
      need2_d[k] = need2_q[k];
      got1_d[k]  = got1_q[k];
      got2_d[k]  = got2_q[k];
    end
    rr_ptr_d   = rr_ptr_q;
    rf_idx     = oc.RF_OCID[2:0];
    rf_slot    = oc.RF_OCID[3];
    rf_accept  = 1'b0;

    if (oc.RF_Data_Valid && ({1'b0, rf_idx} < NUM_CU_W) && (state_q[rf_idx] == CU_COLLECT)) begin
      rf_accept = rf_slot ? (need2_q[rf_idx] && !got2_q[rf_idx])
                          : (need1_q[rf_idx] && !got1_q[rf_idx]);
    end

    if (rf_accept) begin
      if (rf_slot) begin
        src2_d[rf_idx] = oc.RF_Data;
        got2_d[rf_idx] = 1'b1;
      end else begin
        src1_d[rf_idx] = oc.RF_Data;
        got1_d[rf_idx] = 1'b1;
      end
      if ((!need1_d[rf_idx] || got1_d[rf_idx]) && (!need2_d[rf_idx] || got2_d[rf_idx]))
        state_d[rf_idx] = CU_READY;
    end

    alloc_fire = oc.Alloc_Valid && any_free;
    if (alloc_fire) begin
      instr_d[free_idx] = oc.Alloc_Instr;
      need1_d[free_idx] = oc.Alloc_Src1_Need;
      need2_d[free_idx] = oc.Alloc_Src2_Need;
      got1_d[free_idx]  = 1'b0;
      got2_d[free_idx]  = 1'b0;
      state_d[free_idx] = (oc.Alloc_Src1_Need || oc.Alloc_Src2_Need) ? CU_COLLECT : CU_READY;
    end

    disp_fire = any_ready && oc.Disp_Ready;
    if (disp_fire) begin
      state_d[sel_idx] = CU_FREE;
      rr_ptr_d = (sel_idx == 3'(NUM_CU - 1)) ? 3'd0 : sel_idx + 3'd1;
    end
    hold_vld_d = any_ready && !oc.Disp_Ready;
    hold_idx_d = sel_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CU; k++) begin
        state_q[k] <= CU_FREE;
        need1_q[k] <= 1'b0;
        need2_q[k] <= 1'b0;
        got1_q[k]  <= 1'b0;
        got2_q[k]  <= 1'b0;
      end
      rr_ptr_q   <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CU; k++) begin
        state_q[k] <= state_d[k];
        need1_q[k] <= need1_d[k];
        need2_q[k] <= need2_d[k];
        got1_q[k]  <= got1_d[k];
        got2_q[k]  <= got2_d[k];
      end
      rr_ptr_q   <= rr_ptr_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
    end
  end

  // Payload storage is only observed through a valid CU, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CU; k++) begin
      instr_q[k] <= instr_d[k];
      src1_q[k]  <= src1_d[k];
      src2_q[k]  <= src2_d[k];
    end
  end

  assign oc.Alloc_Ready = any_free;
  assign oc.Alloc_OCID  = free_idx;
  assign oc.Disp_Valid  = any_ready;
  assign oc.Disp_OCID   = any_ready ? sel_idx : 3'd0;
  assign oc.Disp_Instr  = any_ready ? instr_q[sel_idx] : 32'd0;
  assign oc.Disp_Src1   = (any_ready && need1_q[sel_idx]) ? src1_q[sel_idx] : 256'd0;
  assign oc.Disp_Src2   = (any_ready && need2_q[sel_idx]) ? src2_q[sel_idx] : 256'd0;

`ifdef OC_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || (oc.RF_Data_Valid && !rf_accept);
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign oc.Err_Illegal_Write = err_q;
`else
  assign oc.Err_Illegal_Write = 1'b0;
`endif
endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: vector table, directed corner sequences, then random traffic against a behavioural model.
module tb_operand_collector;
  localparam int NCU = 8;
  localparam logic [255:0] Z  = 256'h0;
  localparam logic [255:0] D1 = {8{32'h1111_0001}};
  localparam logic [255:0] D2 = {8{32'h2222_0002}};
  localparam logic [255:0] D3 = {8{32'h3333_0003}};
  localparam logic [255:0] D4 = {8{32'h4444_0004}};
`ifdef OC_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_collector_if oc_if ();
  operand_collector #(.NUM_CU(NCU)) dut (.clk(clk), .rst(rst), .oc(oc_if));

  int checks = 0;
  int errors = 0;

  // Reference model: 0=FREE 1=COLLECT 2=READY
  int           m_st   [NCU];
  logic [31:0]  m_instr[NCU];
  logic [255:0] m_s1   [NCU];
  logic [255:0] m_s2   [NCU];
  bit           m_n1[NCU], m_n2[NCU], m_g1[NCU], m_g2[NCU];
  int           m_rr;
  bit           m_lock_v;
  int           m_lock_idx;
  bit           m_err;

  typedef struct {
    logic alloc_v; logic [31:0] instr; logic n1; logic n2;
    logic rf_v; logic [3:0] rf_ocid; logic [255:0] rf_data; logic disp_rdy;
    logic e_ardy; logic [2:0] e_aocid; logic e_dv; logic [2:0] e_docid;
    logic [31:0] e_instr; logic [255:0] e_src1; logic [255:0] e_src2;
  } vec_t;
  vec_t vt[17];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_sel();
    if (m_lock_v) return m_lock_idx;
    for (int k = 0; k < NCU; k++) begin
      if (m_st[(m_rr + k) % NCU] == 2) return (m_rr + k) % NCU;
    end
    return -1;
  endfunction

  function automatic int model_free();
    for (int k = 0; k < NCU; k++) if (m_st[k] == 0) return k;
    return -1;
  endfunction

  task automatic model_update();
    int sel, fr, i;
    bit slot, ok;
    if (!rst) begin
      for (int k = 0; k < NCU; k++) begin
        m_st[k] = 0; m_n1[k] = 0; m_n2[k] = 0; m_g1[k] = 0; m_g2[k] = 0;
      end
      m_rr = 0; m_lock_v = 0; m_lock_idx = 0; m_err = 0;
      return;
    end
    sel = model_sel();
    fr  = model_free();
    if (oc_if.RF_Data_Valid) begin
      i    = int'(oc_if.RF_OCID[2:0]);
      slot = oc_if.RF_OCID[3];
      ok   = (m_st[i] == 1) && (slot ? (m_n2[i] && !m_g2[i]) : (m_n1[i] && !m_g1[i]));
      if (ok) begin
        if (slot) begin m_s2[i] = oc_if.RF_Data; m_g2[i] = 1; end
        else      begin m_s1[i] = oc_if.RF_Data; m_g1[i] = 1; end
        if ((!m_n1[i] || m_g1[i]) && (!m_n2[i] || m_g2[i])) m_st[i] = 2;
      end else begin
        m_err = 1;
      end
    end
    if (oc_if.Alloc_Valid && fr >= 0) begin
      m_instr[fr] = oc_if.Alloc_Instr;
      m_n1[fr] = oc_if.Alloc_Src1_Need; m_n2[fr] = oc_if.Alloc_Src2_Need;
      m_g1[fr] = 0; m_g2[fr] = 0;
      m_st[fr] = (m_n1[fr] || m_n2[fr]) ? 1 : 2;
    end
    if (sel >= 0 && oc_if.Disp_Ready) begin
      m_st[sel] = 0; m_rr = (sel + 1) % NCU; m_lock_v = 0;
    end else begin
      m_lock_v = (sel >= 0); m_lock_idx = sel;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    oc_if.Alloc_Valid = 0; oc_if.Alloc_Instr = '0;
    oc_if.Alloc_Src1_Need = 0; oc_if.Alloc_Src2_Need = 0;
    oc_if.RF_Data_Valid = 0; oc_if.RF_OCID = '0; oc_if.RF_Data = '0;
    oc_if.Disp_Ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic alloc(input logic [31:0] instr, input logic n1, input logic n2);
    oc_if.Alloc_Valid = 1; oc_if.Alloc_Instr = instr;
    oc_if.Alloc_Src1_Need = n1; oc_if.Alloc_Src2_Need = n2;
  endtask

  task automatic rf(input logic [3:0] ocid, input logic [255:0] d);
    oc_if.RF_Data_Valid = 1; oc_if.RF_OCID = ocid; oc_if.RF_Data = d;
  endtask

  task automatic check_model(input string tag);
    int sel, fr;
    sel = model_sel();
    fr  = model_free();
    chk({tag, "_alloc_rdy"}, 256'(oc_if.Alloc_Ready), 256'(fr >= 0));
    if (fr >= 0) chk({tag, "_alloc_ocid"}, 256'(oc_if.Alloc_OCID), 256'(fr));
    chk({tag, "_disp_v"}, 256'(oc_if.Disp_Valid), 256'(sel >= 0));
    if (sel >= 0) begin
      chk({tag, "_disp_ocid"}, 256'(oc_if.Disp_OCID), 256'(sel));
      chk({tag, "_disp_instr"}, 256'(oc_if.Disp_Instr), 256'(m_instr[sel]));
      chk({tag, "_disp_src1"}, oc_if.Disp_Src1, m_n1[sel] ? m_s1[sel] : Z);
      chk({tag, "_disp_src2"}, oc_if.Disp_Src2, m_n2[sel] ? m_s2[sel] : Z);
    end
    chk({tag, "_err"}, 256'(oc_if.Err_Illegal_Write), 256'(ERR_EN && m_err));
  endtask

  initial begin
    vt[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 4'h0, Z,  1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h0, D1, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h8, D2, 1'b0, 1'b1, 3'd1, 1'b1, 3'd0, 32'hA5A5_0001, D1, D2};
    vt[3]  = '{1'b1, 32'h0000_0B0B, 1'b0, 1'b0, 1'b0, 4'h0, Z,  1'b0, 1'b1, 3'd2, 1'b1, 3'd0, 32'hA5A5_0001, D1, D2};
    vt[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, Z,  1'b1, 1'b1, 3'd0, 1'b1, 3'd1, 32'h0000_0B0B, Z,  Z};
    vt[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h1, D3, 1'b0, 1'b1, 3'd0, 1'b1, 3'd1, 32'h0000_0B0B, Z,  Z};
    vt[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, Z,  1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[7]  = '{1'b1, 32'h0000_0C0C, 1'b1, 1'b0, 1'b0, 4'h0, Z,  1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h8, D4, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h0, D3, 1'b0, 1'b1, 3'd1, 1'b1, 3'd0, 32'h0000_0C0C, D3, Z};
    vt[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h0, D4, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[11] = '{1'b1, 32'h0000_0D0D, 1'b1, 1'b1, 1'b0, 4'h0, Z,  1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[12] = '{1'b1, 32'h0000_0E0E, 1'b0, 1'b0, 1'b0, 4'h0, Z,  1'b0, 1'b1, 3'd2, 1'b1, 3'd1, 32'h0000_0E0E, Z,  Z};
    vt[13] = '{1'b1, 32'h0000_0F0F, 1'b1, 1'b0, 1'b1, 4'h0, D1, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 32'h0,        Z,  Z};
    vt[14] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h8, D2, 1'b0, 1'b1, 3'd1, 1'b1, 3'd0, 32'h0000_0D0D, D1, D2};
    vt[15] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 4'h2, D3, 1'b1, 1'b1, 3'd0, 1'b1, 3'd2, 32'h0000_0F0F, D3, Z};
    vt[16] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 4'h0, Z,  1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 32'h0,        Z,  Z};

    do_reset();
    chk("rst_alloc_rdy", 256'(oc_if.Alloc_Ready), 256'(1));
    chk("rst_alloc_ocid", 256'(oc_if.Alloc_OCID), 256'(0));
    chk("rst_disp_v", 256'(oc_if.Disp_Valid), 256'(0));
    chk("rst_disp_instr", 256'(oc_if.Disp_Instr), Z);
    chk("rst_disp_src1", oc_if.Disp_Src1, Z);
    chk("rst_disp_src2", oc_if.Disp_Src2, Z);
    chk("rst_disp_ocid", 256'(oc_if.Disp_OCID), Z);
    chk("rst_err", 256'(oc_if.Err_Illegal_Write), Z);

    for (int r = 0; r < 17; r++) begin
      oc_if.Alloc_Valid = vt[r].alloc_v; oc_if.Alloc_Instr = vt[r].instr;
      oc_if.Alloc_Src1_Need = vt[r].n1;  oc_if.Alloc_Src2_Need = vt[r].n2;
      oc_if.RF_Data_Valid = vt[r].rf_v;  oc_if.RF_OCID = vt[r].rf_ocid;
      oc_if.RF_Data = vt[r].rf_data;     oc_if.Disp_Ready = vt[r].disp_rdy;
      tick();
      chk($sformatf("vec%0d_alloc_rdy", r), 256'(oc_if.Alloc_Ready), 256'(vt[r].e_ardy));
      chk($sformatf("vec%0d_alloc_ocid", r), 256'(oc_if.Alloc_OCID), 256'(vt[r].e_aocid));
      chk($sformatf("vec%0d_disp_v", r), 256'(oc_if.Disp_Valid), 256'(vt[r].e_dv));
      if (vt[r].e_dv) begin
        chk($sformatf("vec%0d_disp_ocid", r), 256'(oc_if.Disp_OCID), 256'(vt[r].e_docid));
        chk($sformatf("vec%0d_disp_instr", r), 256'(oc_if.Disp_Instr), 256'(vt[r].e_instr));
        chk($sformatf("vec%0d_disp_src1", r), oc_if.Disp_Src1, vt[r].e_src1);
        chk($sformatf("vec%0d_disp_src2", r), oc_if.Disp_Src2, vt[r].e_src2);
      end
    end

    // Full array; a CU freed by dispatch is re-granted only on the next cycle
    do_reset();
    for (int k = 0; k < NCU; k++) begin
      alloc(32'h3500_0000 + 32'(k), 1'b1, 1'b1);
      tick();
    end
    chk("full_alloc_rdy", 256'(oc_if.Alloc_Ready), 256'(0));
    rf(4'h3, D1); tick();
    rf(4'hB, D2); tick();
    oc_if.RF_Data_Valid = 0;
    chk("full_disp_ocid", 256'(oc_if.Disp_OCID), 256'(3));
    chk("full_disp_v", 256'(oc_if.Disp_Valid), 256'(1));
    oc_if.Disp_Ready = 1;
    tick();
    chk("regrant_alloc_rdy", 256'(oc_if.Alloc_Ready), 256'(1));
    chk("regrant_alloc_ocid", 256'(oc_if.Alloc_OCID), 256'(3));
    oc_if.Disp_Ready = 0;
    oc_if.Alloc_Instr = 32'h3500_00FF;
    tick();
    chk("regrant_full", 256'(oc_if.Alloc_Ready), 256'(0));
    oc_if.Alloc_Valid = 0;
    rf(4'h3, D3); tick();
    rf(4'hB, D4); tick();
    oc_if.RF_Data_Valid = 0;
    chk("regrant_instr", 256'(oc_if.Disp_Instr), 256'(32'h3500_00FF));
    chk("regrant_src1", oc_if.Disp_Src1, D3);

    // Round-robin order 2,5,7 with Disp_Ready held high
    do_reset();
    for (int k = 0; k < NCU; k++) begin
      if (k == 2 || k == 5 || k == 7) alloc(32'h3600_0000 + 32'(k), 1'b0, 1'b0);
      else                             alloc(32'h3600_0000 + 32'(k), 1'b1, 1'b1);
      tick();
    end
    oc_if.Alloc_Valid = 0;
    oc_if.Disp_Ready  = 1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rr_order%0d", j), 256'(oc_if.Disp_OCID), 256'((j == 0) ? 2 : (j == 1) ? 5 : 7));
      tick();
    end
    chk("rr_drained", 256'(oc_if.Disp_Valid), 256'(0));
    rf(4'h6, D1); tick();
    oc_if.Disp_Ready = 0;
    rf(4'hE, D2);
    alloc(32'h36AA_0000, 1'b0, 1'b0);
    tick();
    idle();
    chk("rr_ptr_zero", 256'(oc_if.Disp_OCID), 256'(2));

    // Duplicate write after Got1
    do_reset();
    alloc(32'h3700_0000, 1'b1, 1'b1); tick();
    oc_if.Alloc_Valid = 0;
    rf(4'h0, D1); tick();
    rf(4'h0, D3); tick();
    rf(4'h8, D2); tick();
    idle();
    chk("dup_disp_v", 256'(oc_if.Disp_Valid), 256'(1));
    chk("dup_src1", oc_if.Disp_Src1, D1);
    chk("dup_src2", oc_if.Disp_Src2, D2);
    chk("dup_err", 256'(oc_if.Err_Illegal_Write), 256'(ERR_EN));

    // Reset mid-collection
    do_reset();
    alloc(32'h3800_0000, 1'b1, 1'b1); tick();
    alloc(32'h3800_0001, 1'b1, 1'b1); tick();
    oc_if.Alloc_Valid = 0;
    rf(4'h1, D1); tick();
    rst = 0;
    rf(4'h9, D2); tick();
    rst = 1;
    oc_if.RF_Data_Valid = 0;
    chk("midrst_alloc_rdy", 256'(oc_if.Alloc_Ready), 256'(1));
    chk("midrst_alloc_ocid", 256'(oc_if.Alloc_OCID), 256'(0));
    chk("midrst_disp_v", 256'(oc_if.Disp_Valid), 256'(0));
    chk("midrst_err", 256'(oc_if.Err_Illegal_Write), 256'(0));
    rf(4'h1, D3); tick();
    rf(4'h9, D4); tick();
    oc_if.RF_Data_Valid = 0;
    chk("midrst_drop_v", 256'(oc_if.Disp_Valid), 256'(0));
    chk("midrst_drop_ocid", 256'(oc_if.Alloc_OCID), 256'(0));
    chk("midrst_drop_err", 256'(oc_if.Err_Illegal_Write), 256'(ERR_EN));

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199, 0) != 0);
      oc_if.Alloc_Valid     = $urandom_range(1, 0) == 1;
      oc_if.Alloc_Instr     = $urandom;
      oc_if.Alloc_Src1_Need = $urandom_range(1, 0) == 1;
      oc_if.Alloc_Src2_Need = $urandom_range(1, 0) == 1;
      oc_if.RF_Data_Valid   = $urandom_range(9, 0) < 6;
      oc_if.RF_OCID         = 4'($urandom_range(15, 0));
      oc_if.RF_Data         = {8{$urandom}};
      oc_if.RF_Data[31:0]   = $urandom;
      oc_if.Disp_Ready      = $urandom_range(2, 0) != 0;
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter NUM_CU, default 8, number of collector units (CUs); legal range 2..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port Alloc_Valid  input  1  an issued instruction requests a CU.
REQ-005 SHALL have port Alloc_Ready  output  1  at least one CU is FREE.
REQ-006 SHALL have port Alloc_Instr  input  32  instruction word to hold.
REQ-007 SHALL have ports Alloc_Src1_Need and Alloc_Src2_Need  input  1 each  operand slot must be collected.
REQ-008 SHALL have port Alloc_OCID  output  3  index of the CU granted this cycle; upstream tags RF read requests with it.
REQ-009 SHALL have port RF_Data_Valid  input  1  RF read data is present this cycle.
REQ-010 SHALL have port RF_OCID  input  4  [3] operand slot (0=src1, 1=src2); [2:0] CU index.
REQ-011 SHALL have port RF_Data  input  256  operand row, 8 lanes x 32 bit.
REQ-012 SHALL have ports Disp_Valid (output, 1) and Disp_Ready (input, 1)  dispatch handshake to execute stage.
REQ-013 SHALL have ports Disp_Instr (output, 32), Disp_Src1 (output, 256), Disp_Src2 (output, 256) and Disp_OCID (output, 3)  contents of the dispatched CU.
REQ-014 SHALL have port Err_Illegal_Write  output  1  sticky illegal-RF-write flag.

Function
REQ-015 Each CU SHALL hold state FREE, COLLECT or READY, plus Instr, Src1, Src2, Need1, Need2, Got1 and Got2.
REQ-016 Alloc_Ready SHALL equal the OR of all CU FREE states, sampled at cycle start.
REQ-017 Alloc_OCID SHALL be the lowest-index FREE CU.
REQ-018 Alloc handshake (Alloc_Valid & Alloc_Ready): granted CU SHALL load Instr/Need1/Need2, clear Got1/Got2, and go to COLLECT; if both Need bits are 0 it SHALL go directly to READY.
REQ-019 RF write SHALL be accepted only when the target CU is in COLLECT and the addressed slot has Need=1 and Got=0; accepted write SHALL store RF_Data and set Got.
REQ-020 Any other RF write (CU FREE or READY, Need=0, Got=1, or index >= NUM_CU) SHALL be dropped with no state change.
REQ-021 A CU SHALL go COLLECT->READY on the edge where (Need1->Got1) and (Need2->Got2) both hold including the write of that cycle; Disp_Valid SHALL therefore rise no earlier than 1 cycle after the last operand write.
REQ-022 Dispatch select SHALL be round-robin over READY CUs, searching upward from pointer rr_ptr (reset 0) with wrap-around.
REQ-023 Disp_Valid SHALL be 1 when any CU is READY; Disp_* SHALL show the selected CU combinationally and SHALL remain stable while Disp_Valid & !Disp_Ready.
REQ-024 Dispatch handshake (Disp_Valid & Disp_Ready): selected CU SHALL go to FREE; rr_ptr SHALL become (selected+1) mod NUM_CU.
REQ-025 A CU freed by dispatch SHALL NOT be allocatable in the same cycle; alloc, RF write and dispatch to different CUs in one cycle SHALL all take effect.
REQ-026 Disp_Src1/Disp_Src2 for a slot with Need=0 SHALL be 256'h0.

Reset
REQ-027 While rst=0 at a rising edge, all CUs SHALL become FREE, Got/Need bits SHALL clear, rr_ptr SHALL become 0, and Err_Illegal_Write SHALL become 0.
REQ-028 After reset, Alloc_Ready SHALL be 1, Alloc_OCID SHALL be 0, and Disp_Valid SHALL be 0; Disp_Instr, Disp_Src1, Disp_Src2 and Disp_OCID SHALL be 0.
REQ-029 Reset mid-collection SHALL discard all partially collected operands; RF writes in the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro OC_ERR_CHECK_EN SHALL control error checking.
REQ-031 When OC_ERR_CHECK_EN is defined, any write dropped per REQ-020 SHALL set Err_Illegal_Write from the next cycle until reset.
REQ-032 When OC_ERR_CHECK_EN is undefined, Err_Illegal_Write SHALL be tied 0 and no check logic SHALL exist.

Verification
REQ-033 Reset, then alloc Instr=32'hA5A5_0001 with Need1=Need2=1 -> Alloc_OCID=0; RF writes OCID=4'h0 then OCID=4'h8 -> Disp_Valid=1 one cycle after the second write, with correct Src1/Src2.
REQ-034 Alloc with Need1=Need2=0 -> Disp_Valid=1 next cycle, Disp_Src1=Disp_Src2=0.
REQ-035 Fill all 8 CUs -> Alloc_Ready=0; dispatch CU3 with Alloc_Valid held -> CU3 is re-granted the following cycle, not the same cycle.
REQ-036 CUs 2, 5 and 7 READY with Disp_Ready=1 continuously -> dispatch order 2, 5, 7; then rr_ptr=0.
REQ-037 Duplicate write OCID=4'h0 to CU0 after Got1 -> Src1 unchanged; Err_Illegal_Write=1 only with OC_ERR_CHECK_EN defined.
REQ-038 Assert rst=0 with CU1 holding Got1 only -> all FREE, no Disp_Valid; a later write to CU1 is dropped.
